// File: rtl/EthernetArbiterPkg.sv
// Shared types for the Ethernet TX arbiter: frame stream bundle,
// arbiter state encoding and counter widths.
package EthernetArbiterPkg;

  localparam int TIMEOUT_W = 16;

  typedef struct packed {
    logic        start;
    logic        data_valid;
    logic [31:0] data;
    logic [1:0]  bytes_valid;
    logic        commit;
    logic        drop;
  } EthernetTxBus;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    FRAME,
    DRAIN
  } arb_state_e;

  function automatic logic frame_end(EthernetTxBus b);
    return b.commit | b.drop;
  endfunction

endpackage

// File: rtl/RoundRobinPriorityEncoder.sv
// Picks the first requester after last_grant, wrapping around.
// Purely combinational.
module RoundRobinPriorityEncoder #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [IW-1:0] grant_idx,
  output logic          valid
);

  logic [IW-1:0] p;

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    grant_idx = '0;
    valid     = 1'b0;
    p         = '0;
    for (int k = N; k >= 1; k--) begin
      p = IW'((int'(last_grant) + k) % N);
      if (req[p]) begin
        grant_idx = p;
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ethernet_tx_arbiter.sv
// Round-robin arbiter muxing several TX frame sources onto one MAC,
// one frame at a time, with start timeout and IFG-aware drain.
module ethernet_tx_arbiter
  import EthernetArbiterPkg::*;
#(
  parameter int NUM_PORTS     = 4,
  parameter int START_TIMEOUT = 255
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_PORTS-1:0]         port_req,
  output logic [NUM_PORTS-1:0]         port_grant,
  input  EthernetTxBus                 port_tx_bus [NUM_PORTS],
  output EthernetTxBus                 mac_tx_bus,
  input  logic                         mac_tx_ready,
  output logic [$clog2(NUM_PORTS)-1:0] active_port,
  output logic                         busy,
  output logic [TIMEOUT_W-1:0]         timeout_count
);

  localparam int IW = $clog2(NUM_PORTS);

  arb_state_e           state_q, state_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d;
  logic [IW-1:0]        last_q, last_d;
  logic [IW-1:0]        act_q, act_d;
  logic [IW-1:0]        rr_idx;
  logic                 rr_valid;
  EthernetTxBus         mac_q, mac_d, gbus;
  logic                 seen_q, seen_d;
  logic [TIMEOUT_W-1:0] wait_q, wait_d;
  logic [TIMEOUT_W-1:0] tmo_q, tmo_d;

  RoundRobinPriorityEncoder #(
    .N (NUM_PORTS)
  ) u_rr (
    .req        (port_req),
    .last_grant (last_q),
    .grant_idx  (rr_idx),
    .valid      (rr_valid)
  );

  assign gbus = port_tx_bus[act_q];

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    act_d   = act_q;
    mac_d   = '0;
    seen_d  = seen_q;
    wait_d  = wait_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      IDLE: begin
        if (mac_tx_ready && rr_valid) begin
          grant_d         = '0;
          grant_d[rr_idx] = 1'b1;
          last_d          = rr_idx;
          act_d           = rr_idx;
          wait_d          = '0;
          state_d         = GRANT;
        end
      end
      GRANT: begin
        if (gbus.start) begin
          mac_d  = gbus;
          seen_d = 1'b0;
          wait_d = '0;
          if (frame_end(gbus)) begin
            grant_d = '0;
            state_d = DRAIN;
          end else begin
            state_d = FRAME;
          end
        end else if (!port_req[act_q]) begin
          grant_d = '0;
          state_d = IDLE;
        end else if (wait_q == TIMEOUT_W'(START_TIMEOUT - 1)) begin
          grant_d = '0;
          wait_d  = '0;
          state_d = IDLE;
          if (tmo_q != '1) tmo_d = tmo_q + 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      FRAME: begin
        mac_d       = gbus;
        mac_d.start = 1'b0;
        if (!mac_tx_ready) seen_d = 1'b1;
        if (frame_end(gbus)) begin
          grant_d = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // A slow MAC may hold ready high for a while after commit.
        if (!mac_tx_ready) seen_d = 1'b1;
        if (seen_q && mac_tx_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IW'(NUM_PORTS - 1);
      act_q   <= '0;
      mac_q   <= '0;
      seen_q  <= 1'b0;
      wait_q  <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      act_q   <= act_d;
      mac_q   <= mac_d;
      seen_q  <= seen_d;
      wait_q  <= wait_d;
      tmo_q   <= tmo_d;
    end
  end

  assign port_grant    = grant_q;
  assign mac_tx_bus    = mac_q;
  assign active_port   = act_q;
  assign busy          = (state_q != IDLE);
  assign timeout_count = tmo_q;

endmodule

// File: tb/tb_ethernet_tx_arbiter.sv
// Randomized scoreboard bench for ethernet_tx_arbiter: expected beats
// and grants are queued by the stimulus and popped by a monitor.
module tb_ethernet_tx_arbiter;
  import EthernetArbiterPkg::*;

  localparam int NP  = 4;
  localparam int TMO = 255;

  logic          clk = 1'b0;
  logic          reset;
  logic [NP-1:0] port_req;
  logic [NP-1:0] port_grant;
  EthernetTxBus  port_tx_bus [NP];
  EthernetTxBus  mac_tx_bus;
  logic          mac_tx_ready;
  logic [1:0]    active_port;
  logic          busy;
  logic [15:0]   timeout_count;

  typedef struct {
    EthernetTxBus b;
    int unsigned  c;
  } beat_t;

  beat_t       exp_q[$];
  int          gexp_q[$];
  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  int          m_last = NP - 1;
  int          m_tmo = 0;
  bit          abort = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ethernet_tx_arbiter #(
    .NUM_PORTS     (NP),
    .START_TIMEOUT (TMO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .port_req      (port_req),
    .port_grant    (port_grant),
    .port_tx_bus   (port_tx_bus),
    .mac_tx_bus    (mac_tx_bus),
    .mac_tx_ready  (mac_tx_ready),
    .active_port   (active_port),
    .busy          (busy),
    .timeout_count (timeout_count)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Round-robin reference: first requester after the last winner.
  function automatic int rr_model(logic [NP-1:0] m, int last);
    logic [NP-1:0] mm;
    mm = m;
    for (int k = 1; k <= NP; k++)
      if (mm[(last + k) % NP]) return (last + k) % NP;
    return -1;
  endfunction

  function automatic int idx_of(logic [NP-1:0] v);
    for (int p = 0; p < NP; p++) if (v[p]) return p;
    return -1;
  endfunction

  function automatic EthernetTxBus rbus();
    EthernetTxBus b;
    b.start       = 1'($urandom);
    b.data_valid  = 1'($urandom);
    b.data        = $urandom;
    b.bytes_valid = 2'($urandom);
    b.commit      = 1'($urandom);
    b.drop        = 1'($urandom);
    return b;
  endfunction

  function automatic logic [NP-1:0] rmask();
    return NP'($urandom_range((1 << NP) - 1, 1));
  endfunction

  initial begin : monitor
    logic [NP-1:0] prev_g;
    beat_t e;
    int g;
    prev_g = '0;
    forever begin
      @(negedge clk);
      if (mac_tx_bus != '0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 64'(mac_tx_bus), 64'(0));
        end else begin
          e = exp_q.pop_front();
          chk("mac_beat", 64'(mac_tx_bus), 64'(e.b));
          chk("beat_latency", 64'(cyc), 64'(e.c));
        end
      end
      if (port_grant != '0 && prev_g == '0) begin
        chk("grant_onehot", 64'($onehot(port_grant)), 64'(1));
        if (gexp_q.size() == 0) begin
          chk("unexpected_grant", 64'(port_grant), 64'(0));
        end else begin
          g = gexp_q.pop_front();
          chk("grant_port", 64'(port_grant), 64'(NP'(1) << g));
          chk("active_port", 64'(active_port), 64'(g));
          chk("busy_on_grant", 64'(busy), 64'(1));
        end
      end
      prev_g = port_grant;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic junk(input int g);
    for (int p = 0; p < NP; p++)
      if (p != g) port_tx_bus[p] = ($urandom_range(1, 0) == 1) ? rbus() : '0;
  endtask

  task automatic send(input int g, input EthernetTxBus b, input bit first);
    EthernetTxBus e;
    port_tx_bus[g] = b;
    e = b;
    if (!first) e.start = 1'b0;
    if (e != '0) exp_q.push_back('{b: e, c: cyc + 1});
    junk(g);
    tick();
  endtask

  task automatic idle_g(input int g, input int n);
    repeat (n) begin
      port_tx_bus[g] = '0;
      junk(g);
      tick();
    end
  endtask

  task automatic wait_grant(output int g);
    g = -1;
    for (int i = 0; i < 40; i++) begin
      if (port_grant != '0) begin
        g = idx_of(port_grant);
        break;
      end
      junk(-1);
      tick();
    end
    if (g < 0) begin
      chk("grant_wait_expired", 64'(0), 64'(1));
      abort = 1'b1;
    end else begin
      port_tx_bus[g] = '0;
    end
  endtask

  task automatic drain(input int d, input int lo);
    for (int i = 0; i < d; i++) begin
      chk("drain_busy", 64'(busy), 64'(1));
      chk("drain_no_grant", 64'(port_grant), 64'(0));
      junk(-1);
      tick();
    end
    mac_tx_ready = 1'b0;
    for (int i = 0; i < lo; i++) begin
      chk("drain_busy_low", 64'(busy), 64'(1));
      chk("drain_no_grant_low", 64'(port_grant), 64'(0));
      junk(-1);
      tick();
    end
    mac_tx_ready = 1'b1;
  endtask

  task automatic frame(input int g, input bit comb, input int nb,
                       input logic [NP-1:0] next, input int d);
    EthernetTxBus b;
    idle_g(g, $urandom_range(3, 0));
    b = rbus();
    b.start  = 1'b1;
    b.commit = 1'b0;
    b.drop   = 1'b0;
    if (comb) begin
      if ($urandom_range(1, 0) == 1) b.commit = 1'b1;
      else b.drop = 1'b1;
    end
    send(g, b, 1'b1);
    if (!comb) begin
      for (int i = 0; i < nb; i++) begin
        b = rbus();
        b.commit     = 1'b0;
        b.drop       = 1'b0;
        b.data_valid = 1'b1;
        b.start      = ($urandom_range(7, 0) == 0);
        send(g, b, 1'b0);
      end
      b = rbus();
      b.start  = 1'b0;
      b.commit = ($urandom_range(1, 0) == 1);
      b.drop   = !b.commit;
      send(g, b, 1'b0);
    end
    port_tx_bus[g] = '0;
    port_req = next;
    drain(d, $urandom_range(8, 1));
  endtask

  task automatic timeout_t(input int g, input logic [NP-1:0] next);
    int n;
    n = 1;
    for (int i = 0; i < TMO + 20; i++) begin
      port_tx_bus[g] = '0;
      junk(g);
      tick();
      if (port_grant[g]) n++;
      else break;
    end
    m_tmo++;
    chk("timeout_len", 64'(n), 64'(TMO));
    chk("timeout_count", 64'(timeout_count), 64'(m_tmo));
    chk("timeout_idle", 64'(busy), 64'(0));
    port_req = next;
  endtask

  task automatic reqdrop_t(input int g, input logic [NP-1:0] next);
    idle_g(g, $urandom_range(3, 0));
    chk("reqdrop_held", 64'(port_grant), 64'(NP'(1) << g));
    port_req = next;
    port_tx_bus[g] = '0;
    junk(g);
    tick();
    chk("reqdrop_release", 64'(port_grant), 64'(0));
    chk("reqdrop_count", 64'(timeout_count), 64'(m_tmo));
  endtask

  initial begin : stim
    EthernetTxBus b;
    logic [NP-1:0] next;
    int g, exp_g, kind;
    reset = 1'b1;
    port_req = '0;
    mac_tx_ready = 1'b1;
    for (int p = 0; p < NP; p++) port_tx_bus[p] = '0;
    #1;
    chk("rst_grant", 64'(port_grant), 64'(0));
    chk("rst_mac", 64'(mac_tx_bus), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_active", 64'(active_port), 64'(0));
    chk("rst_tmo", 64'(timeout_count), 64'(0));
    tick();
    tick();
    port_req = 4'b0110;
    reset = 1'b0;

    for (int it = 0; it < 36; it++) begin
      exp_g = rr_model(port_req, m_last);
      m_last = exp_g;
      gexp_q.push_back(exp_g);
      wait_grant(g);
      if (abort) break;
      next = (it < 3) ? 4'b0110 : rmask();
      if (it == 8 || it == 20) kind = 1;
      else if (it < 4 || it == 5) kind = 0;
      else begin
        case ($urandom_range(3, 0))
          0, 1:    kind = 0;
          2:       kind = 2;
          default: kind = 3;
        endcase
      end
      case (kind)
        0: frame(g, 1'b0, (it == 0) ? 16 : $urandom_range(12, 1), next,
                 (it == 5) ? 100 : $urandom_range(5, 0));
        1: timeout_t(g, next);
        2: begin
          next = next & ~(NP'(1) << g);
          if (next == '0) next = NP'(1) << ((g + 1) % NP);
          reqdrop_t(g, next);
        end
        default: frame(g, 1'b1, 0, next, $urandom_range(5, 0));
      endcase
    end

    if (!abort) begin
      exp_g = rr_model(port_req, m_last);
      m_last = exp_g;
      gexp_q.push_back(exp_g);
      wait_grant(g);
      if (!abort) begin
        b = rbus();
        b.start  = 1'b1;
        b.commit = 1'b0;
        b.drop   = 1'b0;
        send(g, b, 1'b1);
        repeat (3) begin
          b = rbus();
          b.start      = 1'b0;
          b.commit     = 1'b0;
          b.drop       = 1'b0;
          b.data_valid = 1'b1;
          send(g, b, 1'b0);
        end
        reset = 1'b1;
        exp_q.delete();
        #1;
        chk("midrst_grant", 64'(port_grant), 64'(0));
        chk("midrst_mac", 64'(mac_tx_bus), 64'(0));
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_active", 64'(active_port), 64'(0));
        chk("midrst_tmo", 64'(timeout_count), 64'(0));
        m_tmo = 0;
        m_last = NP - 1;
        for (int p = 0; p < NP; p++) port_tx_bus[p] = '0;
        tick();
        tick();
        port_req = rmask();
        exp_g = rr_model(port_req, m_last);
        m_last = exp_g;
        gexp_q.push_back(exp_g);
        reset = 1'b0;
        wait_grant(g);
        if (!abort) begin
          chk("post_rst_lowest", 64'(g), 64'(idx_of(port_req)));
          frame(g, 1'b0, 4, '0, 2);
        end
      end
    end

    repeat (4) tick();
    chk("final_idle", 64'(busy), 64'(0));
    chk("beats_drained", 64'(exp_q.size()), 64'(0));
    chk("grants_drained", 64'(gexp_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ethernet_tx_arbiter.md
ETHERNET_TX_ARBITER -- requirements
Module: ethernet_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, number of TX requesters (2..8).
REQ-002 SHALL have parameter START_TIMEOUT, default 255, max cycles granted port may wait before asserting start.
REQ-003 SHALL have port clk  input  1  sole clock, MAC TX clock domain.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port port_req  input  NUM_PORTS  per-port level request, held until granted frame ends.
REQ-006 SHALL have port port_grant  output  NUM_PORTS  one-hot (or zero) grant.
REQ-007 SHALL have port port_tx_bus  input  NUM_PORTS x EthernetTxBus  per-port frame stream (start, data_valid, data, bytes_valid, commit, drop).
REQ-008 SHALL have port mac_tx_bus  output  EthernetTxBus  registered stream into MAC.
REQ-009 SHALL have port mac_tx_ready  input  1  MAC ready flag (low during frame/IFG).
REQ-010 SHALL have port active_port  output  clog2(NUM_PORTS)  index of current/last grantee.
REQ-011 SHALL have port busy  output  1  high in any state except IDLE.
REQ-012 SHALL have port timeout_count  output  16  saturating count of start timeouts.

Function
REQ-013 SHALL implement states IDLE, GRANT, FRAME, DRAIN.
REQ-014 IDLE: when mac_tx_ready=1 and port_req!=0, SHALL select first requesting port round-robin starting at (last_grant+1) mod NUM_PORTS, assert its port_grant next cycle, update last_grant and active_port, enter GRANT.
REQ-015 IDLE with mac_tx_ready=0 SHALL not grant.
REQ-016 GRANT: start from granted port SHALL be forwarded and enter FRAME; wait counter SHALL clear on entry.
REQ-017 GRANT: if granted port_req drops before start, SHALL release grant and return to IDLE, no count increment.
REQ-018 GRANT: if counter reaches START_TIMEOUT without start, SHALL release grant, increment timeout_count (saturate at 16'hFFFF), return to IDLE.
REQ-019 mac_tx_bus SHALL equal granted port's port_tx_bus delayed exactly one clk, only in GRANT (start only) and FRAME; all fields zero otherwise.
REQ-020 Non-granted port_tx_bus inputs SHALL be ignored entirely.
REQ-021 start from granted port while in FRAME SHALL NOT be forwarded.
REQ-022 FRAME: commit or drop from granted port SHALL be forwarded, port_grant cleared next cycle, enter DRAIN.
REQ-023 A seen_busy flag SHALL clear on forwarding start and set when mac_tx_ready=0 observed in FRAME or DRAIN.
REQ-024 DRAIN: SHALL return to IDLE only when seen_busy=1 and mac_tx_ready=1 (guards 10/100 delayed tx_ready drop, up to 100+ cycles).
REQ-025 Start and commit in same cycle in GRANT: SHALL forward both, enter DRAIN directly.
REQ-026 port_grant SHALL never have more than one bit set.

Reset
REQ-027 On reset: state IDLE, port_grant=0, mac_tx_bus all zero, busy=0, active_port=0, timeout_count=0, seen_busy=0, wait counter=0, last_grant=NUM_PORTS-1 (port 0 wins first).
REQ-028 Reset mid-frame SHALL take effect immediately with no commit/drop emitted; MAC FIFO reset on next start recovers.

Structure
REQ-029 EthernetTxBus typedef SHALL come from existing EthernetBus.svh; arbiter state enum SHALL live in a shared EthernetArbiterPkg package.
REQ-030 Round-robin selection SHALL be one combinational sub-module RoundRobinPriorityEncoder (req, last_grant -> grant index, valid).

Verification
REQ-031 port_req=4'b0110 at reset release, mac_tx_ready=1 -> grant port 1, then port 2, then port 1 alternating.
REQ-032 Granted port sends start + 16 data words + commit -> mac_tx_bus identical, 1-cycle delay, 18 beats.
REQ-033 Granted port never starts, START_TIMEOUT=255 -> grant released after 255 cycles, timeout_count=1.
REQ-034 mac_tx_ready drops 100 cycles after start (10M) and commit arrives first -> stays DRAIN until ready rises again, no early regrant.
REQ-035 Non-granted port 3 drives start/data during port 0 frame -> zero effect on mac_tx_bus.
REQ-036 Reset asserted mid-FRAME -> all outputs zero same cycle; next grant goes to lowest requesting port.
